// File: rtl/mode_power_seq.sv
// Mode/power unit: chunked popcount and parity of a config word,
// then a slew-limited actuator ramp that drains power before a mode flip.
module mode_power_seq #(
  parameter int CONF_W    = 8,
  parameter int CHUNK_W   = 2,
  parameter int RAMP_STEP = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        conf_valid,
  input  logic [CONF_W-1:0]           conf_data,
  output logic                        conf_ready,
  output logic                        res_valid,
  output logic [$clog2(CONF_W+1)-1:0] res_power,
  output logic                        res_mode,
  output logic [$clog2(CONF_W+1)-1:0] act_power,
  output logic                        act_mode,
  output logic                        settled
);

  localparam int PW     = $clog2(CONF_W+1);
  localparam int NCH    = CONF_W / CHUNK_W;
  localparam int CNT_W  = $clog2(NCH+1);
  localparam int STEP_I = (RAMP_STEP > CONF_W) ? CONF_W : RAMP_STEP;
  localparam logic [PW-1:0] STEP = PW'(STEP_I);

  typedef enum logic {
    IDLE,
    COUNT
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [CONF_W-1:0] r_shift;
  logic [PW-1:0]     r_acc;
  logic              r_par;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_res_valid;
  logic [PW-1:0]     r_res_power;
  logic              r_res_mode;
  logic [PW-1:0]     r_act_power;
  logic              r_act_mode;

  logic [PW-1:0]     w_chunk_pc;
  logic              w_chunk_par;
  logic              w_last;
  logic              w_accept;
  logic [PW-1:0]     w_act_power;
  logic              w_act_mode;
  logic [PW-1:0]     w_gap;

  always_comb begin
    w_chunk_pc  = '0;
    w_chunk_par = 1'b0;
    for (int i = 0; i < CHUNK_W; i++) begin
      w_chunk_pc  = w_chunk_pc + PW'(r_shift[i]);
      w_chunk_par = w_chunk_par ^ r_shift[i];
    end
  end

  assign w_last = (r_cnt == CNT_W'(NCH-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (conf_valid) begin
          w_accept = 1'b1;
          w_next   = COUNT;
        end
      end
      COUNT: begin
        if (w_last) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Mode mismatch drains power first; the flip itself costs one cycle at zero.
  always_comb begin
    w_act_power = r_act_power;
    w_act_mode  = r_act_mode;
    w_gap       = '0;
    if (r_act_mode != r_res_mode) begin
      if (r_act_power != '0)
        w_act_power = (r_act_power > STEP) ? r_act_power - STEP : '0;
      else
        w_act_mode = r_res_mode;
    end else if (r_res_power > r_act_power) begin
      w_gap       = r_res_power - r_act_power;
      w_act_power = (w_gap > STEP) ? r_act_power + STEP : r_res_power;
    end else begin
      w_gap       = r_act_power - r_res_power;
      w_act_power = (w_gap > STEP) ? r_act_power - STEP : r_res_power;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift     <= '0;
      r_acc       <= '0;
      r_par       <= 1'b0;
      r_cnt       <= '0;
      r_res_valid <= 1'b0;
      r_res_power <= '0;
      r_res_mode  <= 1'b0;
      r_act_power <= '0;
      r_act_mode  <= 1'b0;
    end else begin
      r_res_valid <= 1'b0;
      if (w_accept) begin
        r_shift <= conf_data;
        r_acc   <= '0;
        r_par   <= 1'b0;
        r_cnt   <= '0;
      end else if (r_state == COUNT) begin
        r_shift <= r_shift >> CHUNK_W;
        r_acc   <= r_acc + w_chunk_pc;
        r_par   <= r_par ^ w_chunk_par;
        r_cnt   <= r_cnt + CNT_W'(1);
        if (w_last) begin
          r_res_power <= r_acc + w_chunk_pc;
          r_res_mode  <= r_par ^ w_chunk_par;
          r_res_valid <= 1'b1;
        end
      end
      r_act_power <= w_act_power;
      r_act_mode  <= w_act_mode;
    end
  end

  assign conf_ready = (r_state == IDLE);
  assign res_valid  = r_res_valid;
  assign res_power  = r_res_power;
  assign res_mode   = r_res_mode;
  assign act_power  = r_act_power;
  assign act_mode   = r_act_mode;
  assign settled    = (r_act_power == r_res_power) &&
                      (r_act_mode == r_res_mode);

endmodule

// File: doc/mode_power_seq.md
Name: mode_power_seq

Overview:
- Sequential, parametrised mode/power unit for the climate-control datapath.
- Accepts a CONF_W-bit configuration word over a valid/ready handshake and counts its set bits CHUNK_W bits per cycle.
  - The count is the target power.
  - The parity (XOR of all bits) is the target mode: 1 = heat, 0 = cool.
- Drives the actuator outputs through a slew-limited ramp. A mode change always ramps power to zero before the mode flips.

Parameters:
- CONF_W, 8: configuration word width. Must be ≥1 and a multiple of CHUNK_W.
- CHUNK_W, 2: bits consumed per counting cycle. 1 ≤ CHUNK_W ≤ CONF_W.
- RAMP_STEP, 1: maximum change of act_power per clock. Must be ≥1.
- Derived localparam PW = $clog2(CONF_W+1): power width.
- Derived localparam NCH = CONF_W/CHUNK_W: counting cycles.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- conf_valid  input  1  conf_data is valid.
- conf_data  input  CONF_W  configuration word.
- conf_ready  output  1  block can accept a word; high only in IDLE.
- res_valid  output  1  one-cycle pulse: res_power and res_mode are new.
- res_power  output  PW  popcount of the last accepted word.
- res_mode  output  1  parity of the last accepted word.
- act_power  output  PW  ramped power applied to the actuator.
- act_mode  output  1  mode applied to the actuator.
- settled  output  1  act_power==res_power and act_mode==res_mode.

Behaviour:
- Reset (async assert, synchronous release):
  - state = IDLE; conf_ready = 1; res_valid = 0.
  - res_power = 0, res_mode = 0, act_power = 0, act_mode = 0; settled = 1.
  - Internal shift register, accumulator and chunk counter = 0.
- FSM has two states: IDLE and COUNT.
- IDLE:
  - conf_ready = 1.
  - On a clock edge with conf_valid=1, the word is accepted: conf_data is latched into the shift register, accumulator = 0, chunk counter = 0, state -> COUNT.
  - conf_data is sampled only at acceptance. Later changes are ignored.
- COUNT:
  - conf_ready = 0 and conf_valid is ignored.
  - Each edge adds popcount(shift[CHUNK_W-1:0]) to the accumulator, XORs those bits into a parity bit, shifts right by CHUNK_W, and increments the counter.
  - At the NCH-th COUNT edge:
    - res_power <= final sum; res_mode <= final parity.
    - res_valid <= 1 for exactly one cycle.
    - state -> IDLE.
- Latency:
  - Acceptance at edge E0 gives res_valid high in the cycle after edge E0+NCH.
  - In that same cycle conf_ready = 1, so back-to-back words are accepted with throughput 1 word per NCH+1 cycles.
- Arithmetic:
  - The accumulator is PW bits wide and never overflows (maximum CONF_W).
  - res_power = CONF_W when all bits are ones.
- Ramp (every cycle, independent of the FSM, uses the current res_* as target):
  - If act_mode != res_mode and act_power > 0: act_power <= act_power - min(RAMP_STEP, act_power).
  - If act_mode != res_mode and act_power == 0: act_mode <= res_mode; act_power is unchanged this cycle.
  - Otherwise, act_power moves toward res_power by min(RAMP_STEP, |res_power - act_power|), with no overshoot.
  - The comparison and the subtraction never underflow.
- settled is combinational from the registered values.
- A new result arriving mid-ramp retargets immediately. If the mode reverts to act_mode before act_power reaches 0, the ramp resumes toward the new power without flipping mode.
- Reset asserted mid-COUNT aborts the word: no res_valid, and all outputs return to reset values.

Test Plan:
- Reset, defaults (CONF_W=8, CHUNK_W=2, STEP=1): release rst_n, hold conf_valid=0 for 5 cycles -> conf_ready=1, res_valid=0, act_power=0, act_mode=0, settled=1 throughout.
- Popcount/parity/latency: accept 8'hB5 at edge E0 -> res_valid high only in the cycle after E0+4; res_power=5, res_mode=1; conf_ready=0 during COUNT. Repeat with 8'h00 (0,0), 8'hFF (8,0) and 8'h01 (1,1).
- Ramp, same mode: from settled 0/cool, send 8'h03 (power 2, cool), then 8'h0F (power 4, cool) -> act_power steps 0,1,2 then 2,3,4, one step per cycle; settled=1 when each ramp ends.
- Mode change: settled at power 4/cool, send 8'h07 (3, heat) -> act_power goes 3,2,1,0; then one cycle with act_mode flipping to 1 at power 0; then 1,2,3. act_mode never reads 1 while act_power>0 before the flip.
- Back-to-back and ignore: hold conf_valid=1 with a new word each cycle -> accepts are exactly NCH+1 edges apart; words presented during COUNT are dropped; each res_valid matches its accepted word.
- Reset mid-COUNT and parameter sweep: assert rst_n low at the second COUNT edge -> no res_valid, all outputs reset. Rerun the popcount checks with CONF_W=12, CHUNK_W=3 (12'hFFF -> res_power=12, res_mode=0, latency 4) and with RAMP_STEP=3 (a 0->8 ramp goes 3,6,8).
